// File: rtl/rx_pkg.sv
// Receive-chain shared constants and types used by the discriminator
// configuration sequencer.
package rx_pkg;

  localparam int CHANNELS         = 8;
  localparam int SAMPLE_WIDTH     = 16;
  localparam int MAX_DELAY_CYCLES = 64;
  localparam int TIMER_BITS       = $clog2(MAX_DELAY_CYCLES);
  localparam int TX_CHANNELS      = 8;
  localparam int TRIG_SEL_BITS    = $clog2(CHANNELS + TX_CHANNELS);

  localparam int THR_W = 2 * CHANNELS * SAMPLE_WIDTH;
  localparam int DLY_W = 3 * CHANNELS * TIMER_BITS;
  localparam int SEL_W = CHANNELS * TRIG_SEL_BITS;
  localparam int DIS_W = CHANNELS;

  // "disable" is a reserved word, hence disable_mask.
  typedef struct packed {
    logic [THR_W-1:0] thresholds;
    logic [DLY_W-1:0] delays;
    logic [SEL_W-1:0] trigger_select;
    logic [DIS_W-1:0] disable_mask;
  } disc_cfg_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SYNC_WAIT,
    RESET_PULSE,
    SETTLE
  } disc_seq_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cfg_stream_issuer.sv
// One valid/ready configuration stream: captures a word on start, offers it
// until accepted (or aborted) and remembers that it was accepted.
module cfg_stream_issuer #(
  parameter int W = 8
) (
  input  logic         adc_clk,
  input  logic         adc_reset_n,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         done_o
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = done_q;
    if (start_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
      done_d  = 1'b0;
    end else if (abort_i) begin
      valid_d = 1'b0;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge adc_clk or negedge adc_reset_n) begin
    if (!adc_reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  // Includes the handshake cycle itself so the sequencer can leave ISSUE on it.
  assign done_o  = done_q | (valid_q & ready_i);

endmodule

// File: rtl/discriminator_config_sequencer.sv
// Atomic discriminator reconfiguration: issue config words, wait for CDC
// settling, pulse the discriminator state clear, then re-arm capture.
//   state       | meaning
//   IDLE        | accepting a request
//   ISSUE       | config words offered on all four streams
//   SYNC_WAIT   | config crossing into the discriminator domain
//   RESET_PULSE | one-cycle hysteresis / sample-counter clear
//   SETTLE      | quiet period before capture re-arms
module discriminator_config_sequencer
  import rx_pkg::*;
#(
  parameter int SYNC_CYCLES    = 16,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             adc_clk,
  input  logic             adc_reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [THR_W-1:0] req_thresholds,
  input  logic [DLY_W-1:0] req_delays,
  input  logic [SEL_W-1:0] req_trigger_select,
  input  logic [DIS_W-1:0] req_disable,
  output logic [THR_W-1:0] thr_data,
  output logic             thr_valid,
  input  logic             thr_ready,
  output logic [DLY_W-1:0] dly_data,
  output logic             dly_valid,
  input  logic             dly_ready,
  output logic [SEL_W-1:0] sel_data,
  output logic             sel_valid,
  input  logic             sel_ready,
  output logic [DIS_W-1:0] dis_data,
  output logic             dis_valid,
  input  logic             dis_ready,
  output logic             adc_reset_state,
  output logic             capture_enable,
  output logic             busy,
  output logic             cfg_error
);

  localparam int CNT_MAX = max3(SYNC_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SYNC_LOAD   = CNT_W'(SYNC_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_TC  = CNT_W'(TIMEOUT_CYCLES - 1);

  if (SYNC_CYCLES < 1 || SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cycles
    $error("SYNC_CYCLES, SETTLE_CYCLES and TIMEOUT_CYCLES must each be >= 1");
  end

  disc_seq_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cap_en_q, cap_en_d;
  logic             cfg_error_q, cfg_error_d;
  logic             start, abort, all_done;
  logic             thr_done, dly_done, sel_done, dis_done;
  disc_cfg_t        req_cfg;

  assign req_cfg = '{thresholds:     req_thresholds,
                     delays:         req_delays,
                     trigger_select: req_trigger_select,
                     disable_mask:   req_disable};

  // The issuers' hold registers double as the request capture register.
  cfg_stream_issuer #(.W(THR_W)) u_thr (
    .adc_clk, .adc_reset_n, .start_i(start), .abort_i(abort),
    .data_i(req_cfg.thresholds), .data_o(thr_data), .valid_o(thr_valid),
    .ready_i(thr_ready), .done_o(thr_done));

  cfg_stream_issuer #(.W(DLY_W)) u_dly (
    .adc_clk, .adc_reset_n, .start_i(start), .abort_i(abort),
    .data_i(req_cfg.delays), .data_o(dly_data), .valid_o(dly_valid),
    .ready_i(dly_ready), .done_o(dly_done));

  cfg_stream_issuer #(.W(SEL_W)) u_sel (
    .adc_clk, .adc_reset_n, .start_i(start), .abort_i(abort),
    .data_i(req_cfg.trigger_select), .data_o(sel_data), .valid_o(sel_valid),
    .ready_i(sel_ready), .done_o(sel_done));

  cfg_stream_issuer #(.W(DIS_W)) u_dis (
    .adc_clk, .adc_reset_n, .start_i(start), .abort_i(abort),
    .data_i(req_cfg.disable_mask), .data_o(dis_data), .valid_o(dis_valid),
    .ready_i(dis_ready), .done_o(dis_done));

  assign all_done = thr_done & dly_done & sel_done & dis_done;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_en_d    = cap_en_q;
    cfg_error_d = cfg_error_q;
    start       = 1'b0;
    abort       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          start       = 1'b1;
          state_d     = ISSUE;
          cnt_d       = '0;
          cap_en_d    = 1'b0;
          cfg_error_d = 1'b0;
        end
      end
      ISSUE: begin
        if (all_done) begin
          state_d = SYNC_WAIT;
          cnt_d   = SYNC_LOAD;
        end else if (cnt_q == TIMEOUT_TC) begin
          abort       = 1'b1;
          cfg_error_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SYNC_WAIT: begin
        if (cnt_q == '0) state_d = RESET_PULSE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESET_PULSE: begin
        state_d = SETTLE;
        cnt_d   = SETTLE_LOAD;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d  = IDLE;
          cap_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge adc_clk or negedge adc_reset_n) begin
    if (!adc_reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cap_en_q    <= 1'b0;
      cfg_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_en_q    <= cap_en_d;
      cfg_error_q <= cfg_error_d;
    end
  end

  assign req_ready       = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign adc_reset_state = (state_q == RESET_PULSE);
  assign capture_enable  = cap_en_q;
  assign cfg_error       = cfg_error_q;

endmodule

// File: tb/tb_discriminator_config_sequencer.sv
// Scoreboard bench: stimulus pushes expected configs, a timeline-model monitor
// checks handshakes, pulse timing, capture re-arm, busy and timeout behaviour.
module tb_discriminator_config_sequencer;
  import rx_pkg::*;

  localparam int SYNC   = 16;
  localparam int SETTLE = 4;
  localparam int TMO    = 1024;

  logic             adc_clk = 1'b0;
  logic             adc_reset_n;
  logic             req_valid, req_ready;
  logic [THR_W-1:0] req_thresholds;
  logic [DLY_W-1:0] req_delays;
  logic [SEL_W-1:0] req_trigger_select;
  logic [DIS_W-1:0] req_disable;
  logic [THR_W-1:0] thr_data;
  logic [DLY_W-1:0] dly_data;
  logic [SEL_W-1:0] sel_data;
  logic [DIS_W-1:0] dis_data;
  logic             thr_valid, dly_valid, sel_valid, dis_valid;
  logic             thr_ready, dly_ready, sel_ready, dis_ready;
  logic             adc_reset_state, capture_enable, busy, cfg_error;

  discriminator_config_sequencer #(
    .SYNC_CYCLES(SYNC), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .adc_clk(adc_clk), .adc_reset_n(adc_reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_thresholds(req_thresholds), .req_delays(req_delays),
    .req_trigger_select(req_trigger_select), .req_disable(req_disable),
    .thr_data(thr_data), .thr_valid(thr_valid), .thr_ready(thr_ready),
    .dly_data(dly_data), .dly_valid(dly_valid), .dly_ready(dly_ready),
    .sel_data(sel_data), .sel_valid(sel_valid), .sel_ready(sel_ready),
    .dis_data(dis_data), .dis_valid(dis_valid), .dis_ready(dis_ready),
    .adc_reset_state(adc_reset_state), .capture_enable(capture_enable),
    .busy(busy), .cfg_error(cfg_error));

  always #5 adc_clk = ~adc_clk;

  typedef struct {
    logic [THR_W-1:0] thr;
    logic [DLY_W-1:0] dly;
    logic [SEL_W-1:0] sel;
    logic [DIS_W-1:0] dis;
  } req_t;

  req_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   mode  = 0;       // 0: readys high, 1: fixed per-stream delays, 3: random
  int   rd[4];           // index 3=thr 2=dly 1=sel 0=dis; -1 = never ready

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  function automatic req_t rand_req();
    req_t q;
    for (int i = 0; i < THR_W / 32; i++) q.thr[i*32 +: 32] = $urandom();
    for (int i = 0; i < DLY_W / 16; i++) q.dly[i*16 +: 16] = 16'($urandom());
    q.sel = $urandom();
    q.dis = 8'($urandom());
    return q;
  endfunction

  // Ready generator: each ready rises a set number of cycles after its valid.
  initial begin : ready_gen
    logic [3:0] v, pv, r;
    int age[4];
    int rnd[4];
    int d;
    pv = '0;
    r  = '0;
    for (int i = 0; i < 4; i++) begin age[i] = 0; rnd[i] = 0; end
    {thr_ready, dly_ready, sel_ready, dis_ready} = 4'b0;
    forever begin
      @(posedge adc_clk);
      #1;
      v = {thr_valid, dly_valid, sel_valid, dis_valid};
      for (int i = 0; i < 4; i++) begin
        if (v[i]) begin
          if (!pv[i]) begin
            age[i] = 0;
            rnd[i] = $urandom_range(0, 6);
          end else begin
            age[i]++;
          end
          d = (mode == 3) ? rnd[i] : (mode == 0) ? 0 : rd[i];
          r[i] = (d >= 0) && (age[i] >= d);
        end else begin
          r[i] = (mode == 0) ? 1'b1 : (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
      end
      pv = v;
      {thr_ready, dly_ready, sel_ready, dis_ready} = r;
    end
  end

  // Monitor with timeline model: request accepted at cycle A, valids at A+1,
  // last handshake L -> pulse at L+1+SYNC, capture at pulse+1+SETTLE,
  // no completion by A+TMO -> idle with cfg_error at A+TMO+1.
  initial begin : monitor
    int   acc, fin, pulse_at, cap_at, err_at;
    bit   exp_cap, exp_err, seq, ebusy;
    logic [3:0] got, vv, rr, evv;
    req_t cur;
    acc = -1; fin = -1; pulse_at = -1; cap_at = -1; err_at = -1;
    exp_cap = 0; exp_err = 0; got = '0;
    cur = '{thr: '0, dly: '0, sel: '0, dis: '0};
    forever begin
      @(negedge adc_clk);
      cyc++;
      vv = {thr_valid, dly_valid, sel_valid, dis_valid};
      rr = {thr_ready, dly_ready, sel_ready, dis_ready};
      if (!adc_reset_n) begin
        acc = -1; fin = -1; pulse_at = -1; cap_at = -1; err_at = -1;
        exp_cap = 0; exp_err = 0;
        exp_q.delete();
        chk("reset_valids", 256'(vv), 256'(0));
        chk("reset_req_ready", 256'(req_ready), 256'(1));
        chk("reset_flags", 256'({adc_reset_state, capture_enable, busy, cfg_error}), 256'(0));
        chk("reset_data", 256'({|thr_data, |dly_data, |sel_data, |dis_data}), 256'(0));
        continue;
      end
      if (cap_at == cyc) exp_cap = 1;
      if (err_at == cyc) exp_err = 1;
      if (acc >= 0 && cyc == acc + 1) begin
        exp_cap = 0;
        exp_err = 0;
        if (exp_q.size() == 0) chk("scoreboard_empty", 256'(1), 256'(0));
        else cur = exp_q.pop_front();
        chk("first_issue_valids", 256'(vv), 256'(4'hF));
      end
      seq   = (acc >= 0) && (cyc > acc);
      ebusy = seq && (fin < 0 || cyc <= fin);
      chk("busy", 256'(busy), 256'(ebusy));
      chk("req_ready", 256'(req_ready), 256'(!ebusy));
      chk("capture_enable", 256'(capture_enable), 256'(exp_cap));
      chk("cfg_error", 256'(cfg_error), 256'(exp_err));
      chk("adc_reset_state", 256'(adc_reset_state), 256'(cyc == pulse_at));
      for (int i = 0; i < 4; i++) evv[i] = seq && (cyc <= acc + TMO) && !got[i];
      chk("valids", 256'(vv), 256'(evv));
      if (ebusy) begin
        chk("thr_data", 256'(thr_data), 256'(cur.thr));
        chk("dly_data", 256'(dly_data), 256'(cur.dly));
        chk("sel_data", 256'(sel_data), 256'(cur.sel));
        chk("dis_data", 256'(dis_data), 256'(cur.dis));
      end
      if (seq && fin < 0) begin
        for (int i = 0; i < 4; i++) if (evv[i] && rr[i]) got[i] = 1'b1;
        if (got == 4'hF) begin
          pulse_at = cyc + 1 + SYNC;
          cap_at   = pulse_at + 1 + SETTLE;
          fin      = cap_at - 1;
        end else if (cyc == acc + TMO) begin
          fin    = cyc;
          err_at = cyc + 1;
        end
      end
      if (acc >= 0 && fin >= 0 && cyc >= fin) acc = -1;
      if (req_valid && !ebusy) begin
        acc = cyc;
        fin = -1;
        got = '0;
      end
    end
  end

  task automatic send(input req_t q);
    bit ok;
    ok = 0;
    @(posedge adc_clk);
    #1;
    req_thresholds     = q.thr;
    req_delays         = q.dly;
    req_trigger_select = q.sel;
    req_disable        = q.dis;
    req_valid          = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge adc_clk);
      if (req_ready) begin
        exp_q.push_back(q);
        ok = 1;
        break;
      end
    end
    if (!ok) chk("req_accept_timeout", 256'(0), 256'(1));
    @(posedge adc_clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    bit ok;
    ok = 0;
    for (int k = 0; k < lim; k++) begin
      @(negedge adc_clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 256'(0), 256'(1));
  endtask

  initial begin : stim
    req_t q;
    adc_reset_n        = 1'b0;
    req_valid          = 1'b0;
    req_thresholds     = '0;
    req_delays         = '0;
    req_trigger_select = '0;
    req_disable        = '0;
    for (int i = 0; i < 4; i++) rd[i] = 0;
    repeat (3) @(posedge adc_clk);
    #1 adc_reset_n = 1'b1;

    // Thresholds lo=-100 / hi=200 on every channel, all readys high.
    q = rand_req();
    for (int ch = 0; ch < CHANNELS; ch++) q.thr[ch*32 +: 32] = {16'd200, 16'(-100)};
    q.dis = '0;
    send(q);
    wait_idle(100);

    // Staggered readys: thr 3, dly 10, sel 1, dis 7 cycles after valid.
    mode = 1;
    rd[3] = 3; rd[2] = 10; rd[1] = 1; rd[0] = 7;
    send(rand_req());
    wait_idle(100);

    // dis_ready never asserts: abort after TMO ISSUE cycles.
    rd[3] = 0; rd[2] = 0; rd[1] = 0; rd[0] = -1;
    send(rand_req());
    wait_idle(TMO + 100);
    chk("timeout_err_cap", 256'({cfg_error, capture_enable}), 256'(2'b10));
    mode = 0;
    send(rand_req());
    wait_idle(100);
    chk("error_cleared", 256'({cfg_error, capture_enable}), 256'(2'b01));

    // Second request held high during SYNC_WAIT.
    q = rand_req();
    send(q);
    repeat (5) @(posedge adc_clk);
    send(q);
    wait_idle(100);

    // Asynchronous reset mid-SYNC_WAIT.
    send(rand_req());
    repeat (5) @(posedge adc_clk);
    #3 adc_reset_n = 1'b0;
    #1;
    chk("async_reset_now",
        256'({thr_valid, dly_valid, sel_valid, dis_valid, adc_reset_state,
              capture_enable, busy, cfg_error, req_ready}),
        256'(9'b0_0000_0001));
    repeat (2) @(posedge adc_clk);
    #1 adc_reset_n = 1'b1;
    send(rand_req());
    wait_idle(100);

    // Back-to-back, only the disable mask changes.
    q = rand_req();
    q.dis = 8'h00;
    send(q);
    q.dis = 8'hFF;
    send(q);
    wait_idle(100);
    chk("dis_data_hold", 256'(dis_data), 256'(8'hFF));

    // Random readys and data.
    mode = 3;
    repeat (8) begin
      send(rand_req());
      if ($urandom_range(0, 1) == 1) wait_idle(200);
    end
    wait_idle(200);

    repeat (2) @(posedge adc_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
